// File: rtl/rr_mux_if.sv
// Handshake bundle between CHANNELS producers and one registered output of rr_mux.
interface rr_mux_if #(
  parameter int WIDTH    = 8,
  parameter int CHANNELS = 4
);
  localparam int SELW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

  logic [CHANNELS-1:0]       in_valid;
  logic [CHANNELS*WIDTH-1:0] in_data;
  logic [CHANNELS-1:0]       in_ready;
  logic                      out_valid;
  logic [WIDTH-1:0]          out_data;
  logic [SELW-1:0]           out_chan;
  logic                      out_ready;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_chan
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, out_chan
  );
endinterface

// File: rtl/rr_mux.sv
// N-to-1 arbitrating multiplexer (round-robin or fixed priority) with a
// single registered output stage and valid/ready flow control.
module rr_mux #(
  parameter int WIDTH    = 8,
  parameter int CHANNELS = 4,
  parameter int MODE     = 0
) (
  input logic   clk,
  input logic   rst,
  rr_mux_if.slave bus
);
  localparam int              SELW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
  localparam logic [SELW:0]   CH_W = (SELW+1)'(CHANNELS);
  localparam logic [SELW-1:0] LAST = SELW'(CHANNELS - 1);

  logic [SELW-1:0]     ptr;
  logic                vld_p1;
  logic [WIDTH-1:0]    data_p1;
  logic [SELW-1:0]     chan_p1;

  logic [CHANNELS-1:0] grant;
  logic [SELW-1:0]     gsel;
  logic                found;
  logic [SELW:0]       cand;
  logic [WIDTH-1:0]    sel_data;
  logic                load_en;
  logic                accept;

  // Stage p0: combinational arbitration, re-evaluated every cycle from live in_valid
  always_comb begin
    grant = '0;
    gsel  = '0;
    found = 1'b0;
    cand  = '0;
    for (int k = 0; k < CHANNELS; k++) begin
      if (MODE == 1) begin
        cand = (SELW+1)'(k);
      end else begin
        cand = {1'b0, ptr} + (SELW+1)'(k);
        if (cand >= CH_W) cand = cand - CH_W;
      end
      if (!found && bus.in_valid[cand[SELW-1:0]]) begin
        found = 1'b1;
        gsel  = cand[SELW-1:0];
      end
    end
    grant[gsel] = found;
  end

  always_comb begin
    sel_data = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      if (grant[i]) sel_data = sel_data | bus.in_data[i*WIDTH +: WIDTH];
    end
  end

  // Grant itself is never gated by out_ready; only the ready back to producers is.
  assign load_en      = !vld_p1 | bus.out_ready;
  assign bus.in_ready = rst ? '0 : (grant & {CHANNELS{load_en}});
  assign accept       = load_en & found & !rst;

  // Stage p1: output register and rotating pointer
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p1  <= 1'b0;
      data_p1 <= '0;
      chan_p1 <= '0;
      ptr     <= '0;
    end else if (accept) begin
      vld_p1  <= 1'b1;
      data_p1 <= sel_data;
      chan_p1 <= gsel;
      ptr     <= (gsel == LAST) ? '0 : gsel + 1'b1;
    end else if (bus.out_ready) begin
      vld_p1  <= 1'b0;
    end
  end

  assign bus.out_valid = vld_p1;
  assign bus.out_data  = data_p1;
  assign bus.out_chan  = chan_p1;
endmodule

// File: doc/rr_mux.md
RR_MUX -- requirements
Module: rr_mux

Interface
REQ-001 SHALL have parameter WIDTH, default 8, data bits per channel (1..64).
REQ-002 SHALL have parameter CHANNELS, default 4, number of input channels (2..16).
REQ-003 SHALL have parameter MODE, default 0, where 0 selects round-robin arbitration and 1 selects fixed priority with the lowest index winning.
REQ-004 SHALL derive SELW = max(1, ceil(log2(CHANNELS))) internally; it is not a user parameter.
REQ-005 SHALL use one clock; reset is synchronous and active-high.
REQ-006 clk  input  1  rising-edge clock for all state.
REQ-007 rst  input  1  synchronous active-high reset.
REQ-008 in_valid  input  CHANNELS  bit i set means channel i offers data.
REQ-009 in_data  input  CHANNELS*WIDTH  channel i occupies bits [i*WIDTH +: WIDTH].
REQ-010 in_ready  output  CHANNELS  bit i set means channel i's word is accepted this cycle.
REQ-011 out_valid  output  1  output register holds a word.
REQ-012 out_data  output  WIDTH  registered selected word.
REQ-013 out_chan  output  SELW  index of the channel that supplied out_data.
REQ-014 out_ready  input  1  downstream accepts out_data this cycle.

Function
REQ-015 SHALL accept a transfer on channel i when in_valid[i] and in_ready[i] are both 1 at a rising clk edge.
REQ-016 SHALL define load_en = !out_valid | out_ready.
REQ-017 SHALL drive in_ready[i] = load_en & grant[i], where grant is one-hot or zero; in_ready SHALL be combinational and SHALL NOT depend on in_data.
REQ-018 SHALL set grant to zero when no in_valid bit is set; otherwise exactly one grant bit SHALL be set.
REQ-019 In MODE 0, SHALL select the first valid channel found searching upward from pointer ptr, wrapping modulo CHANNELS.
REQ-020 In MODE 1, SHALL select the lowest-index valid channel and SHALL ignore ptr.
REQ-021 On an accepted transfer from channel g, SHALL update ptr to (g+1) mod CHANNELS, wrapping CHANNELS-1 to 0.
REQ-022 SHALL leave ptr unchanged in cycles with no accepted transfer, including stalled cycles where out_valid=1 and out_ready=0.
REQ-023 On an accepted transfer, SHALL load out_data with the granted word, load out_chan with g, and set out_valid=1 on the same edge, giving 1-cycle latency.
REQ-024 SHALL clear out_valid when out_valid=1, out_ready=1, and no transfer is accepted.
REQ-025 SHALL sustain one word per cycle when out_ready is held high and inputs are continuously valid.
REQ-026 While out_valid=1 and out_ready=0, out_data and out_chan SHALL hold stable and all in_ready bits SHALL be 0.
REQ-027 A channel SHALL be allowed to drop in_valid before being granted; the arbiter SHALL re-evaluate each cycle with no latched request.
REQ-028 SHALL not gate grant with out_ready, so grant remains valid when it is 0; only in_ready is gated by load_en.
REQ-029 Under round-robin with all channels valid, each channel SHALL be granted exactly once in every CHANNELS consecutive accepted transfers.
REQ-030 When CHANNELS is not a power of two, ptr SHALL never take values of CHANNELS or above.

Reset
REQ-031 While rst=1 at an edge, SHALL set out_valid=0, out_data=0, out_chan=0, and ptr=0.
REQ-032 While rst=1, SHALL force all in_ready bits to 0, so no transfer is accepted in the reset cycle.
REQ-033 Reset asserted mid-stall SHALL discard the held word; the first grant after reset SHALL follow ptr=0 ordering.

Verification
REQ-034 Bench SHALL cover: CHANNELS=4, MODE=0, in_valid=4'b1111, out_ready=1, data 8'hA0+i -> out_chan sequence 0,1,2,3,0 on consecutive cycles, one cycle after each grant.
REQ-035 Bench SHALL cover: MODE=1, in_valid=4'b1110 held, out_ready=1 -> out_chan stays 1 on every cycle and channels 2 and 3 are never granted.
REQ-036 Bench SHALL cover: word from channel 2 = 8'h5C in the output register, out_ready=0 for 3 cycles -> out_data=8'h5C and out_chan=2 stable, in_ready=0, ptr unchanged; out_ready=1 -> the next grant goes to channel 3 if valid.
REQ-037 Bench SHALL cover: CHANNELS=3, only channel 2 valid, out_ready=1 -> grant 2, ptr wraps to 0, and the next grant with in_valid=3'b111 is channel 0.
REQ-038 Bench SHALL cover: rst=1 pulsed during a stall -> out_valid=0, out_data=0, out_chan=0, in_ready=0 next cycle, and the first grant after reset uses ptr=0.
REQ-039 Bench SHALL cover: in_valid=0 with out_ready=1 after one word -> out_valid falls to 0 after one cycle and in_ready stays 0.
